// File: rtl/cart_mem_responder.sv
// Memory-side responder for the cartridge mapper hub: edge-detects level-style
// read/write requests on two ports and serialises them onto one strobe/ready RAM port.
module cart_mem_responder #(
  parameter logic [24:0] ROM_BASE  = 25'h000_0000,
  parameter logic [24:0] SRAM_BASE = 25'h1FF_8000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [24:0] mem_addr [2],
  input  logic [7:0]  mem_data [2],
  input  logic [1:0]  mem_wren,
  input  logic [1:0]  mem_rden,
  output logic [7:0]  mem_q [2],
  output logic        cpu_wait,
  output logic [24:0] ram_addr,
  output logic [7:0]  ram_din,
  output logic        ram_rd,
  output logic        ram_we,
  input  logic [7:0]  ram_dout,
  input  logic        ram_ready
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        sel_q, sel_d;
  logic [1:0]  rd_q, wr_q;
  logic [1:0]  pend_q, pend_d;
  logic [1:0]  kind_wr_q, kind_wr_d;
  logic [24:0] slot_addr_q [2];
  logic [24:0] slot_addr_d [2];
  logic [7:0]  slot_data_q [2];
  logic [7:0]  slot_data_d [2];
  logic [24:0] ram_addr_q, ram_addr_d;
  logic [7:0]  ram_din_q, ram_din_d;
  logic        ram_rd_q, ram_rd_d;
  logic        ram_we_q, ram_we_d;
  logic [7:0]  rdata_q [2];
  logic [7:0]  rdata_d [2];

  logic [1:0]  rise_rd, rise_wr, detect;
  logic [24:0] new_addr [2];
  logic [1:0]  eff_pend, eff_wr;
  logic [24:0] eff_addr [2];
  logic [7:0]  eff_data [2];
  logic        issue, pick;
  logic [9:0]  sram_addr_unused;

  assign rise_rd = mem_rden & ~rd_q;
  assign rise_wr = mem_wren & ~wr_q;
  assign detect  = rise_rd | rise_wr;

  // The SRAM window is 32 KB, so only the low 15 address bits select a byte.
  assign new_addr[0]      = mem_addr[0] + ROM_BASE;
  assign new_addr[1]      = SRAM_BASE + {10'b0, mem_addr[1][14:0]};
  assign sram_addr_unused = mem_addr[1][24:15];

  // Slot contents as seen this cycle: a fresh rise overwrites the stored slot
  // and can be issued on this very edge; a simultaneous read rise loses to the write.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      eff_pend[n] = pend_q[n] | detect[n];
      eff_wr[n]   = detect[n] ? rise_wr[n]  : kind_wr_q[n];
      eff_addr[n] = detect[n] ? new_addr[n] : slot_addr_q[n];
      eff_data[n] = detect[n] ? mem_data[n] : slot_data_q[n];
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // through the block can leave a value unassigned and infer a latch.
    state_d     = state_q;
    sel_d       = sel_q;
    pend_d      = eff_pend;
    kind_wr_d   = eff_wr;
    slot_addr_d = eff_addr;
    slot_data_d = eff_data;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    ram_rd_d    = ram_rd_q;
    ram_we_d    = ram_we_q;
    rdata_d     = rdata_q;
    issue       = 1'b0;
    pick        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|eff_pend) begin
          issue = 1'b1;
          pick  = ~eff_pend[0];
        end
      end
      ST_BUSY: begin
        if (ram_ready) begin
          ram_rd_d = 1'b0;
          ram_we_d = 1'b0;
          if (ram_rd_q) begin
            rdata_d[sel_q] = ram_dout;
          end
          if (eff_pend[~sel_q]) begin
            issue = 1'b1;
            pick  = ~sel_q;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (issue) begin
      state_d      = ST_BUSY;
      sel_d        = pick;
      ram_addr_d   = eff_addr[pick];
      ram_din_d    = eff_data[pick];
      ram_rd_d     = ~eff_wr[pick];
      ram_we_d     = eff_wr[pick];
      pend_d[pick] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every register sample pre-edge
    // values, so the order of statements here cannot change behaviour.
    if (reset) begin
      state_q        <= ST_IDLE;
      sel_q          <= 1'b0;
      rd_q           <= 2'b00;
      wr_q           <= 2'b00;
      pend_q         <= 2'b00;
      kind_wr_q      <= 2'b00;
      // NOTE: these small arrays are plain flops, not RAM, so they are reset
      // like any other register and the slots start out clean.
      slot_addr_q[0] <= '0;
      slot_addr_q[1] <= '0;
      slot_data_q[0] <= '0;
      slot_data_q[1] <= '0;
      ram_addr_q     <= '0;
      ram_din_q      <= '0;
      ram_rd_q       <= 1'b0;
      ram_we_q       <= 1'b0;
      rdata_q[0]     <= 8'hFF;
      rdata_q[1]     <= 8'hFF;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      rd_q        <= mem_rden;
      wr_q        <= mem_wren;
      pend_q      <= pend_d;
      kind_wr_q   <= kind_wr_d;
      slot_addr_q <= slot_addr_d;
      slot_data_q <= slot_data_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      ram_rd_q    <= ram_rd_d;
      ram_we_q    <= ram_we_d;
      rdata_q     <= rdata_d;
    end
  end

  assign cpu_wait = (|detect) | (|pend_q) | (state_q == ST_BUSY);
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign ram_rd   = ram_rd_q;
  assign ram_we   = ram_we_q;
  assign mem_q    = rdata_q;

endmodule

// File: tb/tb_cart_mem_responder.sv
// Self-checking bench for cart_mem_responder: directed vector table, hand-written
// reset/wrap sequences, and randomized rounds against a transaction-level model.
module tb_cart_mem_responder;

  localparam int MAX_WAIT = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic [24:0] mem_addr [2];
  logic [7:0]  mem_data [2];
  logic [1:0]  mem_wren, mem_rden;
  logic [7:0]  mem_q [2];
  logic        cpu_wait;
  logic [24:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_rd, ram_we;
  logic [7:0]  ram_dout;
  logic        ram_ready;

  logic [7:0]  w_mem_q [2];
  logic        w_cpu_wait;
  logic [24:0] w_ram_addr;
  logic [7:0]  w_ram_din;
  logic        w_ram_rd, w_ram_we;

  always #5 clk = ~clk;

  cart_mem_responder dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_wren(mem_wren), .mem_rden(mem_rden), .mem_q(mem_q), .cpu_wait(cpu_wait),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_rd(ram_rd), .ram_we(ram_we),
    .ram_dout(ram_dout), .ram_ready(ram_ready)
  );

  // Shares every input with dut, so it runs in lockstep; only its address differs.
  cart_mem_responder #(.ROM_BASE(25'h1FF_FFFF)) dut_wrap (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_wren(mem_wren), .mem_rden(mem_rden), .mem_q(w_mem_q), .cpu_wait(w_cpu_wait),
    .ram_addr(w_ram_addr), .ram_din(w_ram_din), .ram_rd(w_ram_rd), .ram_we(w_ram_we),
    .ram_dout(ram_dout), .ram_ready(ram_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  din;
    logic        we;
    int          dly;
  } txn_t;

  typedef struct {
    logic [1:0]  k0, k1;      // bit0 = read rise, bit1 = write rise
    logic [24:0] a0, a1;
    logic [7:0]  d0, d1;
    int          delay;
    logic [7:0]  dout;
    int          exp_n;
    logic [24:0] exp_addr0, exp_addr1;
    logic        exp_we0;
    logic [7:0]  exp_din0;
    logic [7:0]  exp_q0, exp_q1;
    int          exp_waits;
  } vec_t;

  // Behavioural backing memory; untouched bytes read back as a fixed pattern.
  logic [7:0] mem_m [logic [24:0]];

  function automatic logic [7:0] mem_peek(input logic [24:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  // Backing-memory responder: logs each access, holds ready off for a chosen
  // number of cycles, and checks that strobe/address/data stay stable meanwhile.
  bit         resp_en     = 1'b0;
  int         fixed_delay = -1;
  int         max_delay   = 4;
  bit         dout_forced = 1'b0;
  logic [7:0] forced_dout = 8'h00;
  txn_t       log_q [$];
  bit         in_txn      = 1'b0;
  int         left        = 0;
  txn_t       cur;

  always @(negedge clk) begin
    ram_ready = 1'b0;
    if (!resp_en) begin
      in_txn = 1'b0;
    end else if (ram_rd || ram_we) begin
      check("strobe_excl", ram_rd & ram_we, 1'b0);
      if (!in_txn) begin
        in_txn   = 1'b1;
        left     = (fixed_delay >= 0) ? fixed_delay : $urandom_range(0, max_delay);
        cur.addr = ram_addr;
        cur.din  = ram_din;
        cur.we   = ram_we;
        cur.dly  = left;
        log_q.push_back(cur);
      end else begin
        check("strobe_hold", {ram_we, ram_din, ram_addr}, {cur.we, cur.din, cur.addr});
      end
      if (left == 0) begin
        ram_ready = 1'b1;
        in_txn    = 1'b0;
        if (cur.we) begin
          mem_m[cur.addr] = cur.din;
          ram_dout        = 8'($urandom);
        end else begin
          ram_dout = dout_forced ? forced_dout : mem_peek(cur.addr);
        end
      end else begin
        left--;
      end
    end
  end

  task automatic wait_idle(input string name);
    for (int i = 0; i < MAX_WAIT; i++) begin
      if (!cpu_wait) break;
      @(negedge clk); #2;
    end
    check(name, cpu_wait, 1'b0);
  endtask

  task automatic drop_levels();
    mem_rden = 2'b00;
    mem_wren = 2'b00;
    @(negedge clk); #2;
  endtask

  // Raise the requested levels in one cycle, count cycles with cpu_wait high
  // (the detection cycle included), then release the levels.
  task automatic run_round(input logic [1:0] k0, input logic [1:0] k1,
                           input logic [24:0] a0, input logic [24:0] a1,
                           input logic [7:0] d0, input logic [7:0] d1,
                           output int waits);
    log_q.delete();
    mem_addr[0] = a0;
    mem_addr[1] = a1;
    mem_data[0] = d0;
    mem_data[1] = d1;
    mem_rden    = {k1[0], k0[0]};
    mem_wren    = {k1[1], k0[1]};
    #1;
    check("wait_rise", cpu_wait, 1'b1);
    #1;
    waits = 1;
    for (int i = 0; i < MAX_WAIT; i++) begin
      @(negedge clk); #2;
      if (!cpu_wait) break;
      waits++;
    end
    check("wait_fall", cpu_wait, 1'b0);
    check("strobes_idle", {ram_rd, ram_we}, 2'b00);
    drop_levels();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t        vecs [4];
    txn_t        exp_ops [$];
    txn_t        e;
    logic [7:0]  eq [2];
    logic [1:0]  k0, k1, kk;
    logic [24:0] a0, a1, ew_addr;
    logic [7:0]  d0, d1, ew_data;
    bit          ew_valid;
    int          waits, exp_waits, n;

    vecs[0] = '{k0: 2'd1, k1: 2'd0, a0: 25'h00_4000, a1: 25'h0, d0: 8'h00, d1: 8'h00,
                delay: 0, dout: 8'hA5, exp_n: 1, exp_addr0: 25'h00_4000, exp_addr1: 25'h0,
                exp_we0: 1'b0, exp_din0: 8'h00, exp_q0: 8'hA5, exp_q1: 8'hFF, exp_waits: 2};
    vecs[1] = '{k0: 2'd0, k1: 2'd2, a0: 25'h0, a1: 25'h1_8123, d0: 8'h00, d1: 8'h3C,
                delay: 2, dout: 8'h00, exp_n: 1, exp_addr0: 25'h1FF_8123, exp_addr1: 25'h0,
                exp_we0: 1'b1, exp_din0: 8'h3C, exp_q0: 8'hA5, exp_q1: 8'hFF, exp_waits: 4};
    vecs[2] = '{k0: 2'd1, k1: 2'd1, a0: 25'h10, a1: 25'h22, d0: 8'h00, d1: 8'h00,
                delay: 3, dout: 8'h5C, exp_n: 2, exp_addr0: 25'h10, exp_addr1: 25'h1FF_8022,
                exp_we0: 1'b0, exp_din0: 8'h00, exp_q0: 8'h5C, exp_q1: 8'h5C, exp_waits: 9};
    vecs[3] = '{k0: 2'd3, k1: 2'd0, a0: 25'h123, a1: 25'h0, d0: 8'h99, d1: 8'h00,
                delay: 1, dout: 8'h11, exp_n: 1, exp_addr0: 25'h123, exp_addr1: 25'h0,
                exp_we0: 1'b1, exp_din0: 8'h99, exp_q0: 8'h5C, exp_q1: 8'h5C, exp_waits: 3};

    reset       = 1'b1;
    mem_rden    = 2'b00;
    mem_wren    = 2'b00;
    mem_addr[0] = '0;
    mem_addr[1] = '0;
    mem_data[0] = '0;
    mem_data[1] = '0;
    ram_dout    = 8'h00;
    ram_ready   = 1'b0;

    repeat (2) @(negedge clk);
    #2;
    check("rst_cpu_wait", cpu_wait, 1'b0);
    check("rst_ram_rd", ram_rd, 1'b0);
    check("rst_ram_we", ram_we, 1'b0);
    check("rst_ram_addr", ram_addr, 25'h0);
    check("rst_ram_din", ram_din, 8'h00);
    check("rst_mem_q0", mem_q[0], 8'hFF);
    check("rst_mem_q1", mem_q[1], 8'hFF);
    reset   = 1'b0;
    resp_en = 1'b1;
    @(negedge clk); #2;

    // Directed vectors
    dout_forced = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fixed_delay = vecs[i].delay;
      forced_dout = vecs[i].dout;
      run_round(vecs[i].k0, vecs[i].k1, vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1, waits);
      check($sformatf("v%0d_count", i), log_q.size(), vecs[i].exp_n);
      if (log_q.size() > 0) begin
        check($sformatf("v%0d_addr0", i), log_q[0].addr, vecs[i].exp_addr0);
        check($sformatf("v%0d_we0", i), log_q[0].we, vecs[i].exp_we0);
        if (vecs[i].exp_we0) check($sformatf("v%0d_din0", i), log_q[0].din, vecs[i].exp_din0);
      end
      if (log_q.size() > 1) check($sformatf("v%0d_addr1", i), log_q[1].addr, vecs[i].exp_addr1);
      check($sformatf("v%0d_q0", i), mem_q[0], vecs[i].exp_q0);
      check($sformatf("v%0d_q1", i), mem_q[1], vecs[i].exp_q1);
      check($sformatf("v%0d_waits", i), waits, vecs[i].exp_waits);
    end
    dout_forced = 1'b0;
    fixed_delay = -1;
    eq[0] = 8'h5C;
    eq[1] = 8'h5C;

    // Port-0 base offset wraps modulo 2^25
    eq[0]       = mem_peek(25'h2);
    mem_addr[0] = 25'h2;
    mem_rden    = 2'b01;
    @(negedge clk); #2;
    check("wrap_main_addr", ram_addr, 25'h2);
    check("wrap_addr", w_ram_addr, 25'h1);
    check("wrap_rd", w_ram_rd, 1'b1);
    wait_idle("wrap_idle");
    check("wrap_q0", mem_q[0], eq[0]);
    drop_levels();

    // Randomized rounds against the transaction model
    for (int r = 0; r < 40; r++) begin
      k0 = 2'($urandom_range(0, 3));
      k1 = 2'($urandom_range(0, 3));
      if (k0 == 2'd0 && k1 == 2'd0) k0 = 2'd1;
      a1 = 25'($urandom);
      a1[14:0] = 15'($urandom_range(0, 7));
      a0 = ($urandom_range(0, 1) == 0) ? 25'($urandom) : 25'h1FF_8000 + 25'($urandom_range(0, 7));
      d0 = 8'($urandom);
      d1 = 8'($urandom);

      exp_ops.delete();
      ew_valid = 1'b0;
      ew_addr  = '0;
      ew_data  = '0;
      for (int p = 0; p < 2; p++) begin
        kk = (p == 0) ? k0 : k1;
        if (kk != 2'd0) begin
          e.we   = kk[1];
          e.addr = (p == 0) ? a0 : 25'h1FF_8000 + {10'd0, a1[14:0]};
          e.din  = (p == 0) ? d0 : d1;
          e.dly  = 0;
          if (e.we) begin
            ew_valid = 1'b1;
            ew_addr  = e.addr;
            ew_data  = e.din;
          end else begin
            eq[p] = (ew_valid && ew_addr == e.addr) ? ew_data : mem_peek(e.addr);
          end
          exp_ops.push_back(e);
        end
      end

      run_round(k0, k1, a0, a1, d0, d1, waits);
      check($sformatf("r%0d_count", r), log_q.size(), exp_ops.size());
      n = (log_q.size() < exp_ops.size()) ? log_q.size() : exp_ops.size();
      exp_waits = 1;
      for (int i = 0; i < n; i++) begin
        check($sformatf("r%0d_addr%0d", r, i), log_q[i].addr, exp_ops[i].addr);
        check($sformatf("r%0d_we%0d", r, i), log_q[i].we, exp_ops[i].we);
        if (exp_ops[i].we) check($sformatf("r%0d_din%0d", r, i), log_q[i].din, exp_ops[i].din);
        exp_waits += log_q[i].dly + 1;
      end
      check($sformatf("r%0d_waits", r), waits, exp_waits);
      check($sformatf("r%0d_q0", r), mem_q[0], eq[0]);
      check($sformatf("r%0d_q1", r), mem_q[1], eq[1]);
    end

    // Reset while BUSY, then a stray late ready
    fixed_delay = 20;
    mem_addr[0] = 25'h77;
    mem_rden    = 2'b01;
    repeat (2) @(negedge clk);
    #2;
    check("abort_busy_rd", ram_rd, 1'b1);
    reset    = 1'b1;
    resp_en  = 1'b0;
    mem_rden = 2'b00;
    @(negedge clk); #2;
    check("abort_rd", ram_rd, 1'b0);
    check("abort_we", ram_we, 1'b0);
    check("abort_q0", mem_q[0], 8'hFF);
    check("abort_q1", mem_q[1], 8'hFF);
    reset     = 1'b0;
    ram_dout  = 8'h77;
    ram_ready = 1'b1;
    @(negedge clk); #2;
    check("stray_q0", mem_q[0], 8'hFF);
    check("stray_q1", mem_q[1], 8'hFF);
    check("stray_wait", cpu_wait, 1'b0);
    check("stray_rd", ram_rd, 1'b0);

    // A level held high through reset yields exactly one request
    reset       = 1'b1;
    mem_addr[1] = 25'h0055;
    mem_rden    = 2'b10;
    @(negedge clk); #2;
    eq[1]       = mem_peek(25'h1FF_8055);
    fixed_delay = 0;
    log_q.delete();
    reset   = 1'b0;
    resp_en = 1'b1;
    #1;
    check("held_wait_rise", cpu_wait, 1'b1);
    #1;
    @(negedge clk); #2;
    wait_idle("held_idle");
    repeat (3) @(negedge clk);
    #2;
    check("held_count", log_q.size(), 1);
    check("held_q1", mem_q[1], eq[1]);
    check("held_wait", cpu_wait, 1'b0);
    drop_levels();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
